// File: rtl/alu_seq_if.sv
// Operand/result bus between the control FSM (master) and the sequential ALU (slave).
interface alu_seq_if #(
    parameter int DATAWIDTH = 8,
    parameter int SELECTION = 4
);
    logic                 sStart;
    logic [SELECTION-1:0] sSelAlu;
    logic [DATAWIDTH-1:0] sDataInBusA;
    logic [DATAWIDTH-1:0] sDataInBusB;
    logic [DATAWIDTH-1:0] sDataOutBusC;
    logic [DATAWIDTH-1:0] sDataOutBusHi;
    logic                 sBusy;
    logic                 sDone;
    logic                 sZero;
    logic                 sNegative;
    logic                 sCarry;
    logic                 sOverflow;

    modport master (
        output sStart, sSelAlu, sDataInBusA, sDataInBusB,
        input  sDataOutBusC, sDataOutBusHi, sBusy, sDone,
               sZero, sNegative, sCarry, sOverflow
    );

    modport slave (
        input  sStart, sSelAlu, sDataInBusA, sDataInBusB,
        output sDataOutBusC, sDataOutBusHi, sBusy, sDone,
               sZero, sNegative, sCarry, sOverflow
    );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with start/busy/done handshake, flags register and a
// shift-add unsigned multiplier that takes one iteration per operand bit.
module alu_seq #(
    parameter int DATAWIDTH = 8,
    parameter int SELECTION = 4
) (
    input  logic        sClk,
    input  logic        sRstN,
    alu_seq_if.slave    bus
);
    localparam int MSB = DATAWIDTH - 1;
    localparam int CW  = $clog2(DATAWIDTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] OP_MUL = 4'hE;

    localparam logic [DATAWIDTH:0] ONE_X = (DATAWIDTH + 1)'(1);

    logic [1:0]             state_r;
    logic [DATAWIDTH-1:0]   a_r;
    logic [DATAWIDTH-1:0]   b_r;
    logic [2*DATAWIDTH-1:0] acc_r;
    logic [CW-1:0]          cnt_r;
    logic [DATAWIDTH-1:0]   c_r;
    logic [DATAWIDTH-1:0]   hi_r;
    logic                   busy_r;
    logic                   done_r;
    logic                   zero_r;
    logic                   neg_r;
    logic                   carry_r;
    logic                   ovf_r;

    logic [3:0]             op_s;
    logic [DATAWIDTH-1:0]   a_s;
    logic [DATAWIDTH-1:0]   b_s;
    logic [DATAWIDTH:0]     sum_s;
    logic [DATAWIDTH-1:0]   res_s;
    logic                   cy_s;
    logic                   ov_s;
    logic                   wr_bus_s;
    logic [2*DATAWIDTH-1:0] addend_s;
    logic [2*DATAWIDTH-1:0] acc_next_s;
    logic [DATAWIDTH-1:0]   prod_lo_s;
    logic [DATAWIDTH-1:0]   prod_hi_s;

    assign op_s = bus.sSelAlu;
    assign a_s  = bus.sDataInBusA;
    assign b_s  = bus.sDataInBusB;

    // Single-cycle datapath: result, carry/borrow and overflow from the live operand bus.
    always_comb begin
        sum_s    = '0;
        res_s    = '0;
        cy_s     = 1'b0;
        ov_s     = 1'b0;
        wr_bus_s = 1'b1;
        case (op_s)
            4'h0: res_s = a_s;
            4'h1: begin
                sum_s = {1'b0, a_s} - {1'b0, b_s};
                res_s = sum_s[MSB:0];
                cy_s  = sum_s[DATAWIDTH];
                ov_s  = (a_s[MSB] != b_s[MSB]) && (res_s[MSB] != a_s[MSB]);
            end
            4'h2: begin
                sum_s = {1'b0, a_s} + {1'b0, b_s};
                res_s = sum_s[MSB:0];
                cy_s  = sum_s[DATAWIDTH];
                ov_s  = (a_s[MSB] == b_s[MSB]) && (res_s[MSB] != a_s[MSB]);
            end
            4'h3: res_s = ~a_s;
            4'h4: res_s = a_s & b_s;
            4'h5: begin
                sum_s = {1'b0, a_s} + ONE_X;
                res_s = sum_s[MSB:0];
                cy_s  = sum_s[DATAWIDTH];
                ov_s  = (a_s[MSB] == 1'b0) && (res_s[MSB] != a_s[MSB]);
            end
            4'h6: begin
                sum_s = {1'b0, a_s} - ONE_X;
                res_s = sum_s[MSB:0];
                cy_s  = sum_s[DATAWIDTH];
                ov_s  = (a_s[MSB] != 1'b0) && (res_s[MSB] != a_s[MSB]);
            end
            4'h7: res_s = a_s | b_s;
            4'h8: res_s = a_s ^ b_s;
            4'h9: begin
                res_s = {a_s[MSB-1:0], 1'b0};
                cy_s  = a_s[MSB];
            end
            4'hA: begin
                res_s = {1'b0, a_s[MSB:1]};
                cy_s  = a_s[0];
            end
            4'hB: begin
                res_s = {a_s[MSB], a_s[MSB:1]};
                cy_s  = a_s[0];
            end
            4'hC: begin
                res_s = {a_s[MSB-1:0], a_s[MSB]};
                cy_s  = a_s[MSB];
            end
            4'hD: begin
                res_s = {a_s[0], a_s[MSB:1]};
                cy_s  = a_s[0];
            end
            4'hF: begin
                // Compare: subtract for flags only, result bus keeps its value.
                sum_s    = {1'b0, a_s} - {1'b0, b_s};
                res_s    = sum_s[MSB:0];
                cy_s     = sum_s[DATAWIDTH];
                ov_s     = (a_s[MSB] != b_s[MSB]) && (res_s[MSB] != a_s[MSB]);
                wr_bus_s = 1'b0;
            end
            default: begin
                res_s    = '0;
                wr_bus_s = 1'b0;
            end
        endcase
    end

    // Multiplier step: add B shifted to the current bit position when that bit of A is set.
    always_comb begin
        if (a_r[cnt_r]) begin
            addend_s = {{DATAWIDTH{1'b0}}, b_r} << cnt_r;
        end else begin
            addend_s = '0;
        end
        acc_next_s = acc_r + addend_s;
        prod_lo_s  = acc_next_s[MSB:0];
        prod_hi_s  = acc_next_s[2*DATAWIDTH-1:DATAWIDTH];
    end

    // Control FSM plus all result, flag and handshake registers.
    always_ff @(posedge sClk or negedge sRstN) begin
        if (!sRstN) begin
            state_r <= ST_IDLE;
            a_r     <= '0;
            b_r     <= '0;
            acc_r   <= '0;
            cnt_r   <= '0;
            c_r     <= '0;
            hi_r    <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            zero_r  <= 1'b0;
            neg_r   <= 1'b0;
            carry_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (bus.sStart) begin
                        if (op_s == OP_MUL) begin
                            a_r     <= a_s;
                            b_r     <= b_s;
                            acc_r   <= '0;
                            cnt_r   <= '0;
                            busy_r  <= 1'b1;
                            state_r <= ST_MUL;
                        end else begin
                            if (wr_bus_s) begin
                                c_r  <= res_s;
                                hi_r <= '0;
                            end
                            zero_r  <= (res_s == '0);
                            neg_r   <= res_s[MSB];
                            carry_r <= cy_s;
                            ovf_r   <= ov_s;
                            done_r  <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    acc_r <= acc_next_s;
                    cnt_r <= cnt_r + CW'(1);
                    if (cnt_r == CW'(DATAWIDTH - 1)) begin
                        // Last partial product folded in: publish product and flags.
                        c_r     <= prod_lo_s;
                        hi_r    <= prod_hi_s;
                        zero_r  <= (acc_next_s == '0);
                        neg_r   <= prod_lo_s[MSB];
                        carry_r <= (prod_hi_s != '0);
                        ovf_r   <= (prod_hi_s != '0);
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Start requests are dropped during the done cycle.
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.sDataOutBusC  = c_r;
    assign bus.sDataOutBusHi = hi_r;
    assign bus.sBusy         = busy_r;
    assign bus.sDone         = done_r;
    assign bus.sZero         = zero_r;
    assign bus.sNegative     = neg_r;
    assign bus.sCarry        = carry_r;
    assign bus.sOverflow     = ovf_r;
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed vector table, multi-cycle MUL and
// reset sequences, and random ops checked against an arithmetic reference model.
module tb_alu_seq;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    alu_seq_if #(.DATAWIDTH(8), .SELECTION(4)) bus ();

    alu_seq #(.DATAWIDTH(8), .SELECTION(4)) dut (
        .sClk  (clk),
        .sRstN (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state (expected outputs).
    int m_c, m_hi, m_z, m_n, m_cy, m_v;

    typedef struct {
        int op; int a; int b;
        int c; int hi; int z; int n; int cy; int v;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int sgn(input int x);
        return (x >= 128) ? x - 256 : x;
    endfunction

    function automatic int out_of_range(input int s);
        return (s > 127 || s < -128) ? 1 : 0;
    endfunction

    // Behavioural model: each opcode's meaning in plain integer arithmetic.
    function automatic void model_apply(input int op, input int a, input int b);
        int r; int cy; int v; int p;
        cy = 0; v = 0; r = 0;
        case (op)
            0:  r = a;
            1:  begin r = (a - b + 256) % 256; cy = (a < b); v = out_of_range(sgn(a) - sgn(b)); end
            2:  begin r = (a + b) % 256; cy = (a + b > 255); v = out_of_range(sgn(a) + sgn(b)); end
            3:  r = 255 - a;
            4:  r = a & b;
            5:  begin r = (a + 1) % 256; cy = (a == 255); v = out_of_range(sgn(a) + 1); end
            6:  begin r = (a + 255) % 256; cy = (a == 0); v = out_of_range(sgn(a) - 1); end
            7:  r = a | b;
            8:  r = a ^ b;
            9:  begin r = (a * 2) % 256; cy = a / 128; end
            10: begin r = a / 2; cy = a % 2; end
            11: begin r = a / 2 + ((a >= 128) ? 128 : 0); cy = a % 2; end
            12: begin r = (a * 2) % 256 + a / 128; cy = a / 128; end
            13: begin r = a / 2 + (a % 2) * 128; cy = a % 2; end
            14: begin
                p = a * b;
                m_c = p % 256; m_hi = p / 256;
                m_z = (p == 0); m_n = (m_c >= 128);
                m_cy = (m_hi != 0); m_v = (m_hi != 0);
                return;
            end
            default: begin r = (a - b + 256) % 256; cy = (a < b); v = out_of_range(sgn(a) - sgn(b)); end
        endcase
        if (op != 15) begin
            m_c = r; m_hi = 0;
        end
        m_z = (r == 0); m_n = (r >= 128); m_cy = cy; m_v = v;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, " busC"}, 32'(bus.sDataOutBusC), 32'(m_c));
        chk({tag, " busHi"}, 32'(bus.sDataOutBusHi), 32'(m_hi));
        chk({tag, " Z"}, 32'(bus.sZero), 32'(m_z));
        chk({tag, " N"}, 32'(bus.sNegative), 32'(m_n));
        chk({tag, " C"}, 32'(bus.sCarry), 32'(m_cy));
        chk({tag, " V"}, 32'(bus.sOverflow), 32'(m_v));
    endtask

    // Issue one single-cycle op; on return the result edge has passed (+1).
    task automatic do_op(input int op, input int a, input int b, input string tag);
        @(negedge clk);
        bus.sStart = 1'b1; bus.sSelAlu = 4'(op);
        bus.sDataInBusA = 8'(a); bus.sDataInBusB = 8'(b);
        @(posedge clk); #1;
        bus.sStart = 1'b0;
        bus.sDataInBusA = 8'($urandom); bus.sDataInBusB = 8'($urandom);
        chk({tag, " done"}, 32'(bus.sDone), 32'd1);
        chk({tag, " busy"}, 32'(bus.sBusy), 32'd0);
    endtask

    task automatic run_mul(input int a, input int b, input bit poke, input string tag);
        int n;
        @(negedge clk);
        bus.sStart = 1'b1; bus.sSelAlu = 4'hE;
        bus.sDataInBusA = 8'(a); bus.sDataInBusB = 8'(b);
        @(posedge clk); #1;
        bus.sStart = 1'b0;
        bus.sDataInBusA = 8'($urandom); bus.sDataInBusB = 8'($urandom);
        chk({tag, " busy@accept"}, 32'(bus.sBusy), 32'd1);
        chk({tag, " done@accept"}, 32'(bus.sDone), 32'd0);
        n = 0;
        while (bus.sDone !== 1'b1 && n < 20) begin
            bus.sStart = poke && (n == 2);
            bus.sSelAlu = 4'h2;
            @(posedge clk); #1;
            n++;
        end
        bus.sStart = 1'b0;
        chk({tag, " latency"}, 32'(n), 32'd8);
        chk({tag, " busy@done"}, 32'(bus.sBusy), 32'd0);
        model_apply(14, a, b);
        check_all(tag);
        // A start during the done cycle must be dropped.
        bus.sStart = 1'b1; bus.sSelAlu = 4'h0; bus.sDataInBusA = 8'h55;
        @(posedge clk); #1;
        bus.sStart = 1'b0;
        chk({tag, " no extra done"}, 32'(bus.sDone), 32'd0);
        check_all({tag, " hold"});
    endtask

    vec_t tbl[$];

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int op; int a; int b;
        checks = 0; errors = 0;
        m_c = 0; m_hi = 0; m_z = 0; m_n = 0; m_cy = 0; m_v = 0;
        bus.sStart = 1'b0; bus.sSelAlu = 4'h0;
        bus.sDataInBusA = 8'h00; bus.sDataInBusB = 8'h00;
        rst_n = 1'b0;
        #1;
        check_all("reset");
        chk("reset busy", 32'(bus.sBusy), 32'd0);
        chk("reset done", 32'(bus.sDone), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        //          op    a      b      C      Hi  Z  N  C  V
        tbl.push_back('{4'h0, 8'h3C, 8'h00, 8'h3C, 0, 0, 0, 0, 0});
        tbl.push_back('{4'hF, 8'h05, 8'h05, 8'h3C, 0, 1, 0, 0, 0});
        tbl.push_back('{4'h2, 8'h7F, 8'h01, 8'h80, 0, 0, 1, 0, 1});
        tbl.push_back('{4'h1, 8'h00, 8'h01, 8'hFF, 0, 0, 1, 1, 0});
        tbl.push_back('{4'h5, 8'hFF, 8'h00, 8'h00, 0, 1, 0, 1, 0});
        tbl.push_back('{4'hD, 8'h01, 8'h00, 8'h80, 0, 0, 1, 1, 0});
        tbl.push_back('{4'hB, 8'h80, 8'h00, 8'hC0, 0, 0, 1, 0, 0});
        tbl.push_back('{4'h9, 8'h80, 8'h00, 8'h00, 0, 1, 0, 1, 0});
        tbl.push_back('{4'h6, 8'h80, 8'h00, 8'h7F, 0, 0, 0, 0, 1});
        tbl.push_back('{4'h2, 8'hFF, 8'h01, 8'h00, 0, 1, 0, 1, 0});
        tbl.push_back('{4'h8, 8'hF0, 8'hFF, 8'h0F, 0, 0, 0, 0, 0});
        tbl.push_back('{4'hF, 8'h01, 8'h02, 8'h0F, 0, 0, 1, 1, 0});
        tbl.push_back('{4'h3, 8'h0F, 8'h00, 8'hF0, 0, 0, 1, 0, 0});
        tbl.push_back('{4'hC, 8'h81, 8'h00, 8'h03, 0, 0, 0, 1, 0});
        tbl.push_back('{4'hA, 8'h81, 8'h00, 8'h40, 0, 0, 0, 1, 0});
        tbl.push_back('{4'h4, 8'hF0, 8'h3C, 8'h30, 0, 0, 0, 0, 0});
        tbl.push_back('{4'h7, 8'hF0, 8'h0F, 8'hFF, 0, 0, 1, 0, 0});
        tbl.push_back('{4'h1, 8'h80, 8'h01, 8'h7F, 0, 0, 0, 0, 1});

        foreach (tbl[i]) begin
            string t;
            t = $sformatf("vec%0d op%0h", i, tbl[i].op);
            do_op(tbl[i].op, tbl[i].a, tbl[i].b, t);
            chk({t, " busC"}, 32'(bus.sDataOutBusC), 32'(tbl[i].c));
            chk({t, " busHi"}, 32'(bus.sDataOutBusHi), 32'(tbl[i].hi));
            chk({t, " Z"}, 32'(bus.sZero), 32'(tbl[i].z));
            chk({t, " N"}, 32'(bus.sNegative), 32'(tbl[i].n));
            chk({t, " C"}, 32'(bus.sCarry), 32'(tbl[i].cy));
            chk({t, " V"}, 32'(bus.sOverflow), 32'(tbl[i].v));
            model_apply(tbl[i].op, tbl[i].a, tbl[i].b);
        end

        // Done pulse lasts a single cycle when no new start follows.
        @(posedge clk); #1;
        chk("done pulse width", 32'(bus.sDone), 32'd0);

        // FF*FF with a start poked while busy.
        run_mul(8'hFF, 8'hFF, 1'b1, "mulFFxFF");
        chk("mulFFxFF hi const", 32'(bus.sDataOutBusHi), 32'hFE);
        chk("mulFFxFF lo const", 32'(bus.sDataOutBusC), 32'h01);
        run_mul(8'h00, 8'h9A, 1'b0, "mul0");
        run_mul(8'h0C, 8'h0B, 1'b0, "mulsmall");

        // CMP after MUL keeps both result halves.
        do_op(4'hF, 8'h10, 8'h20, "cmp after mul");
        model_apply(15, 8'h10, 8'h20);
        check_all("cmp after mul");

        // Random mix, including multiplies.
        for (int k = 0; k < 80; k++) begin
            op = int'($urandom_range(0, 15));
            a  = int'($urandom_range(0, 255));
            b  = int'($urandom_range(0, 255));
            if (k % 9 == 0) a = 255;
            if (k % 11 == 0) b = a;
            if (op == 14) begin
                run_mul(a, b, 1'($urandom_range(0, 1)), $sformatf("rnd%0d mul", k));
            end else begin
                do_op(op, a, b, $sformatf("rnd%0d op%0h", k, op));
                model_apply(op, a, b);
                check_all($sformatf("rnd%0d op%0h", k, op));
            end
        end

        // Asynchronous reset in the middle of a multiply.
        do_op(4'h0, 8'hA5, 8'h00, "pre-reset pass");
        @(negedge clk);
        bus.sStart = 1'b1; bus.sSelAlu = 4'hE;
        bus.sDataInBusA = 8'hFF; bus.sDataInBusB = 8'h03;
        @(posedge clk); #1;
        bus.sStart = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        m_c = 0; m_hi = 0; m_z = 0; m_n = 0; m_cy = 0; m_v = 0;
        check_all("midmul reset");
        chk("midmul reset busy", 32'(bus.sBusy), 32'd0);
        chk("midmul reset done", 32'(bus.sDone), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        do_op(4'h2, 8'h02, 8'h03, "post-reset add");
        model_apply(2, 2, 3);
        check_all("post-reset add");
        chk("post-reset add const", 32'(bus.sDataOutBusC), 32'h05);
        run_mul(8'h07, 8'h06, 1'b0, "post-reset mul");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
